// File: rtl/fnd_pkg.sv
// Shared types, constants and helpers for the 4-digit FND scan display path.
package fnd_pkg;

  localparam int BIN_W     = 14;
  localparam int DIGITS    = 4;
  localparam int BCD_W     = 16;
  localparam int MAX_VALUE = 9999;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } conv_state_e;

  // Common-anode, active-low segment patterns {dp,g,f,e,d,c,b,a}; entry 0 is digit 0.
  localparam logic [9:0][7:0] FONT_TABLE = {
    8'h90, 8'h80, 8'hF8, 8'h82, 8'h92,
    8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };
  localparam logic [7:0] FONT_BLANK = 8'hFF;

  // Segment pattern for one BCD nibble; non-decimal codes show nothing.
  function automatic logic [7:0] font_of(input logic [3:0] nib);
    logic [7:0] f;
    case (nib)
      4'd0:    f = FONT_TABLE[0];
      4'd1:    f = FONT_TABLE[1];
      4'd2:    f = FONT_TABLE[2];
      4'd3:    f = FONT_TABLE[3];
      4'd4:    f = FONT_TABLE[4];
      4'd5:    f = FONT_TABLE[5];
      4'd6:    f = FONT_TABLE[6];
      4'd7:    f = FONT_TABLE[7];
      4'd8:    f = FONT_TABLE[8];
      4'd9:    f = FONT_TABLE[9];
      default: f = FONT_BLANK;
    endcase
    return f;
  endfunction

  // Double-dabble correction: add 3 to every nibble that is 5 or more.
  function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] r;
    r = bcd;
    for (int d = 0; d < DIGITS; d++) begin
      if (r[d*4 +: 4] >= 4'd5) begin
        r[d*4 +: 4] = r[d*4 +: 4] + 4'd3;
      end else begin
        r[d*4 +: 4] = r[d*4 +: 4];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative binary-to-BCD converter with a valid/ready load handshake.
// One accepted value takes 16 cycles: load, 14 shift iterations, commit.
module bin2bcd_seq
  import fnd_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [BIN_W-1:0] i_value,
  input  logic             i_valid,
  output logic             o_ready,
  output logic [BCD_W-1:0] o_bcd,
  output logic             o_done
);

  conv_state_e      state_r;
  logic [BIN_W-1:0] bin_r;
  logic [BCD_W-1:0] scratch_r;
  logic [3:0]       cnt_r;
  logic             ready_r;
  logic             done_r;

  logic [BIN_W-1:0] sat_s;
  logic [BCD_W-1:0] adj_s;

  // Clamp out-of-range inputs and precompute the nibble correction.
  always_comb begin
    sat_s = i_value;
    if (i_value > BIN_W'(MAX_VALUE)) begin
      sat_s = BIN_W'(MAX_VALUE);
    end else begin
      sat_s = i_value;
    end
    adj_s = dabble_adjust(scratch_r);
  end

  // Converter FSM; loads arriving outside IDLE are dropped.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_r   <= IDLE;
      bin_r     <= '0;
      scratch_r <= '0;
      cnt_r     <= 4'd0;
      ready_r   <= 1'b1;
      done_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (i_valid) begin
            bin_r     <= sat_s;
            scratch_r <= '0;
            cnt_r     <= 4'd13;
            ready_r   <= 1'b0;
            state_r   <= SHIFT;
          end else begin
            ready_r <= 1'b1;
          end
        end
        SHIFT: begin
          scratch_r <= {adj_s[BCD_W-2:0], bin_r[BIN_W-1]};
          bin_r     <= {bin_r[BIN_W-2:0], 1'b0};
          if (cnt_r == 4'd0) begin
            done_r  <= 1'b1;
            state_r <= COMMIT;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        COMMIT: begin
          done_r  <= 1'b0;
          ready_r <= 1'b1;
          state_r <= IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          ready_r <= 1'b1;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign o_ready = ready_r;
  assign o_bcd   = scratch_r;
  assign o_done  = done_r;

endmodule

// File: rtl/fnd_scan_driver.sv
// 4-digit common-anode FND back end: binary load, BCD conversion,
// atomic display update and time-multiplexed digit scan.
module fnd_scan_driver
  import fnd_pkg::*;
#(
  parameter int SCAN_DIV = 100_000
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [BIN_W-1:0] i_value,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic             i_blank_lz,
  output logic [1:0]       o_digit_sel,
  output logic [3:0]       o_fnd_com,
  output logic [7:0]       o_fnd_font
);

  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

  logic [BCD_W-1:0] bcd_s;
  logic             done_s;

  logic [BCD_W-1:0] disp_r;
  logic [PW-1:0]    presc_r;
  logic [1:0]       sel_r;
  logic [3:0]       com_r;
  logic [7:0]       font_r;

  logic [3:0]       nib_s;
  logic             upper_zero_s;
  logic [7:0]       font_s;

  bin2bcd_seq u_conv (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_value (i_value),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .o_bcd   (bcd_s),
    .o_done  (done_s)
  );

  // Display register changes only when a whole conversion is finished.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      disp_r <= '0;
    end else if (done_s) begin
      disp_r <= bcd_s;
    end else begin
      disp_r <= disp_r;
    end
  end

  // Free-running prescaler and scan index, independent of the converter.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      presc_r <= '0;
      sel_r   <= 2'd0;
    end else if (presc_r == PRESC_LAST) begin
      presc_r <= '0;
      sel_r   <= sel_r + 2'd1;
    end else begin
      presc_r <= presc_r + PW'(1);
      sel_r   <= sel_r;
    end
  end

  // Pick the current nibble and decide whether it is a leading zero.
  always_comb begin
    nib_s        = 4'd0;
    upper_zero_s = 1'b0;
    case (sel_r)
      2'd0: begin
        nib_s        = disp_r[3:0];
        upper_zero_s = 1'b0;
      end
      2'd1: begin
        nib_s        = disp_r[7:4];
        upper_zero_s = (disp_r[15:4] == 12'd0);
      end
      2'd2: begin
        nib_s        = disp_r[11:8];
        upper_zero_s = (disp_r[15:8] == 8'd0);
      end
      2'd3: begin
        nib_s        = disp_r[15:12];
        upper_zero_s = (disp_r[15:12] == 4'd0);
      end
      default: begin
        nib_s        = 4'd0;
        upper_zero_s = 1'b0;
      end
    endcase
    if (i_blank_lz && upper_zero_s) begin
      font_s = FONT_BLANK;
    end else begin
      font_s = font_of(nib_s);
    end
  end

  // Registered digit enable and segment outputs, one cycle behind the index.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      com_r  <= 4'b1111;
      font_r <= FONT_BLANK;
    end else begin
      com_r  <= ~(4'b0001 << sel_r);
      font_r <= font_s;
    end
  end

  assign o_digit_sel = sel_r;
  assign o_fnd_com   = com_r;
  assign o_fnd_font  = font_r;

endmodule

// File: tb/tb_fnd_scan_driver.sv
// Directed self-checking bench for fnd_scan_driver with SCAN_DIV = 4.
module tb_fnd_scan_driver;

  logic        clk;
  logic        rst;
  logic [13:0] value;
  logic        valid;
  logic        ready;
  logic        blank_lz;
  logic [1:0]  digit_sel;
  logic [3:0]  fnd_com;
  logic [7:0]  fnd_font;

  int n_checks;
  int n_fail;

  fnd_scan_driver #(.SCAN_DIV(4)) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_value     (value),
    .i_valid     (valid),
    .o_ready     (ready),
    .i_blank_lz  (blank_lz),
    .o_digit_sel (digit_sel),
    .o_fnd_com   (fnd_com),
    .o_fnd_font  (fnd_font)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int guard;
    guard = 0;
    while (ready !== 1'b1 && guard < 40) begin
      tick();
      guard++;
    end
    chk({tag, "_ready_wait"}, {31'd0, ready}, 32'd1);
  endtask

  // Load a value and check the ready timing; returns one cycle after the commit edge.
  task automatic load_timed(input string tag, input logic [13:0] v);
    wait_ready(tag);
    value = v;
    valid = 1'b1;
    tick();                                       // edge N
    valid = 1'b0;
    chk({tag, "_ready_N"}, {31'd0, ready}, 32'd0);
    repeat (14) tick();                           // edge N+14
    chk({tag, "_ready_N14"}, {31'd0, ready}, 32'd0);
    tick();                                       // edge N+15
    chk({tag, "_ready_N15"}, {31'd0, ready}, 32'd1);
    tick();
  endtask

  // Wait for digit k to be enabled and check its segment pattern.
  task automatic digit(input string tag, input int k, input logic [7:0] exp_font);
    logic [3:0] want;
    bit found;
    want  = 4'b0001 << k;
    want  = ~want;
    found = 1'b0;
    for (int i = 0; i < 24 && !found; i++) begin
      if (fnd_com === want) found = 1'b1;
      else tick();
    end
    chk({tag, "_com_seen"}, {31'd0, found}, 32'd1);
    chk({tag, "_font"}, {24'd0, fnd_font}, {24'd0, exp_font});
  endtask

  task automatic frame(input string tag, input logic [7:0] f0, input logic [7:0] f1,
                       input logic [7:0] f2, input logic [7:0] f3);
    digit({tag, "_d0"}, 0, f0);
    digit({tag, "_d1"}, 1, f1);
    digit({tag, "_d2"}, 2, f2);
    digit({tag, "_d3"}, 3, f3);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    value    = 14'd0;
    valid    = 1'b0;
    blank_lz = 1'b0;
    #1;
    chk("por_com", {28'd0, fnd_com}, 32'h0000000F);
    chk("por_font", {24'd0, fnd_font}, 32'h000000FF);
    chk("por_ready", {31'd0, ready}, 32'd1);
    chk("por_sel", {30'd0, digit_sel}, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rel_com", {28'd0, fnd_com}, 32'h0000000E);
    chk("rel_font", {24'd0, fnd_font}, 32'h000000C0);

    // Plain conversion, no blanking.
    load_timed("l1234", 14'd1234);
    frame("l1234", 8'h99, 8'hB0, 8'hA4, 8'hF9);

    // Reset mid-frame, held for 3 cycles.
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("rmf_com", {28'd0, fnd_com}, 32'h0000000F);
    chk("rmf_font", {24'd0, fnd_font}, 32'h000000FF);
    chk("rmf_ready", {31'd0, ready}, 32'd1);
    chk("rmf_sel", {30'd0, digit_sel}, 32'd0);
    repeat (3) tick();
    chk("rmf_hold_com", {28'd0, fnd_com}, 32'h0000000F);
    rst = 1'b0;
    tick();
    chk("rmf_rel_com", {28'd0, fnd_com}, 32'h0000000E);
    chk("rmf_rel_font", {24'd0, fnd_font}, 32'h000000C0);
    chk("rmf_rel_sel", {30'd0, digit_sel}, 32'd0);

    // Saturation.
    load_timed("s10000", 14'd10000);
    frame("s10000", 8'h90, 8'h90, 8'h90, 8'h90);
    load_timed("s16383", 14'd16383);
    frame("s16383", 8'h90, 8'h90, 8'h90, 8'h90);

    // Leading-zero blanking.
    blank_lz = 1'b1;
    load_timed("b7", 14'd7);
    frame("b7", 8'hF8, 8'hFF, 8'hFF, 8'hFF);
    load_timed("b0", 14'd0);
    frame("b0", 8'hC0, 8'hFF, 8'hFF, 8'hFF);
    load_timed("b1005", 14'd1005);
    frame("b1005", 8'h92, 8'hC0, 8'hC0, 8'hF9);
    blank_lz = 1'b0;

    // Load while busy is dropped.
    wait_ready("busy");
    value = 14'd5678;
    valid = 1'b1;
    tick();                                       // edge N
    valid = 1'b0;
    repeat (4) tick();
    value = 14'd4321;
    valid = 1'b1;
    tick();                                       // edge N+5
    valid = 1'b0;
    chk("busy_ready_N5", {31'd0, ready}, 32'd0);
    repeat (10) tick();                           // edge N+15
    chk("busy_ready_N15", {31'd0, ready}, 32'd1);
    tick();
    chk("busy_no_accept", {31'd0, ready}, 32'd1);
    frame("busy", 8'h80, 8'hF8, 8'h82, 8'h92);

    // Valid held high: one accept every 16 cycles.
    wait_ready("held");
    value = 14'd1111;
    valid = 1'b1;
    tick();                                       // edge N
    chk("held_N", {31'd0, ready}, 32'd0);
    repeat (14) tick();
    chk("held_N14", {31'd0, ready}, 32'd0);
    tick();
    chk("held_N15", {31'd0, ready}, 32'd1);
    tick();
    chk("held_N16", {31'd0, ready}, 32'd0);
    repeat (14) tick();
    chk("held_N30", {31'd0, ready}, 32'd0);
    tick();
    chk("held_N31", {31'd0, ready}, 32'd1);
    valid = 1'b0;
    tick();
    chk("held_N32", {31'd0, ready}, 32'd1);
    frame("held", 8'hF9, 8'hF9, 8'hF9, 8'hF9);

    // Reset in the middle of a conversion.
    wait_ready("rmc");
    value = 14'd9999;
    valid = 1'b1;
    tick();                                       // edge N
    valid = 1'b0;
    repeat (6) tick();
    rst = 1'b1;
    #1;
    chk("rmc_ready", {31'd0, ready}, 32'd1);
    chk("rmc_com", {28'd0, fnd_com}, 32'h0000000F);
    chk("rmc_font", {24'd0, fnd_font}, 32'h000000FF);
    chk("rmc_sel", {30'd0, digit_sel}, 32'd0);
    repeat (2) tick();
    rst = 1'b0;
    tick();
    chk("rmc_rel_font", {24'd0, fnd_font}, 32'h000000C0);
    repeat (20) tick();
    chk("rmc_idle_ready", {31'd0, ready}, 32'd1);
    frame("rmc_zero", 8'hC0, 8'hC0, 8'hC0, 8'hC0);
    load_timed("l42", 14'd42);
    digit("l42_d0", 0, 8'hA4);
    digit("l42_d1", 1, 8'h99);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
